// File: rtl/multi_cycle_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : multi_cycle_ctrl_pkg
// Description : Shared encodings for the multi-cycle MIPS control path.
// Revision    : 1.0 - initial release
//============================================================================
package multi_cycle_ctrl_pkg;

  // FSM state encodings (4-bit register)
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_IF   = 4'd1;
  localparam logic [3:0] ST_ID   = 4'd2;
  localparam logic [3:0] ST_MA   = 4'd3;
  localparam logic [3:0] ST_MR   = 4'd4;
  localparam logic [3:0] ST_LWB  = 4'd5;
  localparam logic [3:0] ST_MW   = 4'd6;
  localparam logic [3:0] ST_EXR  = 4'd7;
  localparam logic [3:0] ST_RWB  = 4'd8;
  localparam logic [3:0] ST_EXI  = 4'd9;
  localparam logic [3:0] ST_IWB  = 4'd10;
  localparam logic [3:0] ST_BR   = 4'd11;
  localparam logic [3:0] ST_J    = 4'd12;
  localparam logic [3:0] ST_JAL  = 4'd13;
  localparam logic [3:0] ST_JR   = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation select, shared with the ALU
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_XOR  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;
  localparam logic [1:0] M2R_LUI    = 2'd3;

  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_RS = 2'd1;
  localparam logic [1:0] SRCA_RT = 2'd2;

  localparam logic [2:0] SRCB_RT       = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_SEXT     = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'd3;
  localparam logic [2:0] SRCB_SHAMT    = 3'd4;
  localparam logic [2:0] SRCB_ZEXT     = 3'd5;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  function automatic logic is_shift(input logic [5:0] fun);
    return (fun == FN_SLL) || (fun == FN_SRL) || (fun == FN_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_ctrl_alu_op_decode.sv
`default_nettype none
//============================================================================
// Module      : multi_cycle_ctrl_alu_op_decode
// Description : Maps R-type funct and I-type opcode to the 4-bit ALU op.
// Revision    : 1.0 - initial release
//============================================================================
module multi_cycle_ctrl_alu_op_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_fun,
  output logic [3:0] o_funct_op,
  output logic       o_funct_legal,
  output logic [3:0] o_imm_op
);

  // jr is not an ALU funct; the FSM dispatches it before consulting this
  always_comb begin
    o_funct_op    = ALU_ADD;
    o_funct_legal = 1'b1;
    case (i_fun)
      FN_ADD:  o_funct_op = ALU_ADD;
      FN_SUB:  o_funct_op = ALU_SUB;
      FN_AND:  o_funct_op = ALU_AND;
      FN_OR:   o_funct_op = ALU_OR;
      FN_XOR:  o_funct_op = ALU_XOR;
      FN_NOR:  o_funct_op = ALU_NOR;
      FN_SLT:  o_funct_op = ALU_SLT;
      FN_SLTU: o_funct_op = ALU_SLTU;
      FN_SLL:  o_funct_op = ALU_SLL;
      FN_SRL:  o_funct_op = ALU_SRL;
      FN_SRA:  o_funct_op = ALU_SRA;
      default: o_funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    o_imm_op = ALU_ADD;
    case (i_opcode)
      OP_SLTI: o_imm_op = ALU_SLT;
      OP_ANDI: o_imm_op = ALU_AND;
      OP_ORI:  o_imm_op = ALU_OR;
      OP_XORI: o_imm_op = ALU_XOR;
      default: o_imm_op = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
//============================================================================
// Module      : multi_cycle_ctrl
// Description : Control FSM for the multi-cycle MIPS datapath.
// Revision    : 1.0 - initial release
//============================================================================
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       CPU_MIO,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic [3:0] ALU_operation,
  output logic       illegal,
  output logic [3:0] state_out
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_mem_rdy;
  logic [3:0] w_funct_op;
  logic [3:0] w_imm_op;
  logic       w_funct_legal;

  assign w_mem_rdy = MEM_WAIT ? MIO_ready : 1'b1;
  assign CPU_MIO   = MemRead | MemWrite;
  assign state_out = r_state;

  multi_cycle_ctrl_alu_op_decode u_alu_op_decode (
    .i_opcode      (OPcode),
    .i_fun         (Fun),
    .o_funct_op    (w_funct_op),
    .o_funct_legal (w_funct_legal),
    .o_imm_op      (w_imm_op)
  );

  // Async reset forces IDLE, and every output decodes to 0 there, so strobes
  // drop the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = ST_IF;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = REGDST_RT;
    MemtoReg      = M2R_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RT;
    PCSource      = PCSRC_ALU;
    PCWrite       = 1'b0;
    ALU_operation = ALU_ADD;
    illegal       = 1'b0;
    case (r_state)
      ST_IDLE: ALU_operation = ALU_AND;
      ST_IF: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (w_mem_rdy) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = ST_ID;
        end else begin
          w_next  = ST_IF;
        end
      end
      ST_ID: begin
        ALUSrcB = SRCB_SEXT_SH2;
        case (OPcode)
          OP_LW, OP_SW: w_next = ST_MA;
          OP_RTYPE: begin
            if (Fun == FN_JR)       w_next = ST_JR;
            else if (w_funct_legal) w_next = ST_EXR;
            else                    illegal = 1'b1;
          end
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_next = ST_EXI;
          OP_BEQ, OP_BNE: w_next = ST_BR;
          OP_J:           w_next = ST_J;
          OP_JAL:         w_next = ST_JAL;
          default:        illegal = 1'b1;
        endcase
      end
      ST_MA: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_SEXT;
        w_next  = (OPcode == OP_SW) ? ST_MW : ST_MR;
      end
      ST_MR: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = w_mem_rdy ? ST_LWB : ST_MR;
      end
      ST_LWB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
      end
      ST_MW: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = w_mem_rdy ? ST_IF : ST_MW;
      end
      ST_EXR: begin
        if (is_shift(Fun)) begin
          ALUSrcA = SRCA_RT;
          ALUSrcB = SRCB_SHAMT;
        end else begin
          ALUSrcA = SRCA_RS;
          ALUSrcB = SRCB_RT;
        end
        ALU_operation = w_funct_op;
        w_next        = ST_RWB;
      end
      ST_RWB: begin
        RegWrite      = 1'b1;
        RegDst        = REGDST_RD;
        ALU_operation = w_funct_op;
      end
      ST_EXI: begin
        ALUSrcA = SRCA_RS;
        if (OPcode == OP_ADDI || OPcode == OP_SLTI)
          ALUSrcB = SRCB_SEXT;
        else if (OPcode == OP_ANDI || OPcode == OP_ORI || OPcode == OP_XORI)
          ALUSrcB = SRCB_ZEXT;
        ALU_operation = w_imm_op;
        w_next        = ST_IWB;
      end
      ST_IWB: begin
        RegWrite = 1'b1;
        MemtoReg = (OPcode == OP_LUI) ? M2R_LUI : M2R_ALUOUT;
      end
      ST_BR: begin
        ALUSrcA       = SRCA_RS;
        ALU_operation = ALU_SUB;
        PCSource      = PCSRC_ALUOUT;
        PCWrite       = ((OPcode == OP_BEQ) & zero) | ((OPcode == OP_BNE) & ~zero);
      end
      ST_J: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      ST_JAL: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        RegDst   = REGDST_RA;
        MemtoReg = M2R_PC;
      end
      ST_JR: begin
        PCSource = PCSRC_RS;
        PCWrite  = 1'b1;
      end
      default: w_next = ST_IF;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_multi_cycle_ctrl
// Description : Scoreboard bench for multi_cycle_ctrl, directed vectors.
// Revision    : 1.0 - initial release
//============================================================================
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       clk_en;
  logic       rst_n;
  logic [5:0] OPcode, Fun;
  logic       zero, MIO_ready;
  logic       MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, PCWrite, illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, PCSource;
  logic [2:0] ALUSrcB;
  logic [3:0] ALU_operation, state_out;

  typedef struct {
    string       nm;
    logic [26:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event mon_ev;

  multi_cycle_ctrl #(.MEM_WAIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun(Fun), .zero(zero),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite),
    .CPU_MIO(CPU_MIO), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite), .ALU_operation(ALU_operation),
    .illegal(illegal), .state_out(state_out)
  );

  // Gated clock so the asynchronous-reset check can run with no edges at all
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic expect_v(input string nm, input logic [3:0] st,
                          input logic mr, mw, iord, irw, rw,
                          input logic [1:0] rd, m2r, sa, input logic [2:0] sb,
                          input logic [1:0] ps, input logic pw,
                          input logic [3:0] op, input logic ill);
    exp_t e;
    e.nm = nm;
    e.v  = {st, mr, mw, iord, irw, rw, rd, m2r, sa, sb, ps, pw, op, ill, mr | mw};
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input logic [3:0] st,
                     input logic mr, mw, iord, irw, rw,
                     input logic [1:0] rd, m2r, sa, input logic [2:0] sb,
                     input logic [1:0] ps, input logic pw,
                     input logic [3:0] op, input logic ill);
    expect_v(nm, st, mr, mw, iord, irw, rw, rd, m2r, sa, sb, ps, pw, op, ill);
    step();
  endtask

  // IF with memory ready, then a normal ID
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    OPcode = op; Fun = fn; MIO_ready = 1'b1;
    cyc("if",  1, 1,0,0,1,0, 0,0,0,3'd1,0,1, 4'd2, 0);
    cyc("id",  2, 0,0,0,0,0, 0,0,0,3'd3,0,0, 4'd2, 0);
  endtask

  // Monitor: compares whenever the bench has an expectation outstanding
  initial begin
    logic [26:0] act;
    exp_t        e;
    forever begin
      @(negedge clk or mon_ev);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {state_out, MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, PCSource, PCWrite, ALU_operation, illegal, CPU_MIO};
        n_tests++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s @%0t: got %b expected %b (st,mr,mw,iord,irw,rw,rd,m2r,sa,sb,ps,pw,op,ill,mio)",
                   e.nm, $time, act, e.v);
        end
      end
    end
  end

  initial begin
    clk_en = 1'b1; rst_n = 1'b0;
    OPcode = 6'h00; Fun = 6'h00; zero = 1'b0; MIO_ready = 1'b0;
    #1;
    expect_v("reset", 0, 0,0,0,0,0, 0,0,0,3'd0,0,0, 4'd0, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    step();

    cyc("if_stall", 1, 1,0,0,0,0, 0,0,0,3'd1,0,0, 4'd2, 0);

    fetch(6'h00, 6'h20);
    cyc("add_exr",  7, 0,0,0,0,0, 0,0,1,3'd0,0,0, 4'd2, 0);
    cyc("add_rwb",  8, 0,0,0,0,1, 1,0,0,3'd0,0,0, 4'd2, 0);

    fetch(6'h00, 6'h00);
    cyc("sll_exr",  7, 0,0,0,0,0, 0,0,2,3'd4,0,0, 4'd3, 0);
    cyc("sll_rwb",  8, 0,0,0,0,1, 1,0,0,3'd0,0,0, 4'd3, 0);

    fetch(6'h00, 6'h2B);
    cyc("sltu_exr", 7, 0,0,0,0,0, 0,0,1,3'd0,0,0, 4'd9, 0);
    cyc("sltu_rwb", 8, 0,0,0,0,1, 1,0,0,3'd0,0,0, 4'd9, 0);

    fetch(6'h23, 6'h00);
    cyc("lw_ma",    3, 0,0,0,0,0, 0,0,1,3'd2,0,0, 4'd2, 0);
    MIO_ready = 1'b0;
    cyc("lw_mr0",   4, 1,0,1,0,0, 0,0,0,3'd0,0,0, 4'd2, 0);
    cyc("lw_mr1",   4, 1,0,1,0,0, 0,0,0,3'd0,0,0, 4'd2, 0);
    MIO_ready = 1'b1;
    cyc("lw_mr2",   4, 1,0,1,0,0, 0,0,0,3'd0,0,0, 4'd2, 0);
    cyc("lw_lwb",   5, 0,0,0,0,1, 0,1,0,3'd0,0,0, 4'd2, 0);

    fetch(6'h04, 6'h00); zero = 1'b1;
    cyc("beq_z1",  11, 0,0,0,0,0, 0,0,1,3'd0,1,1, 4'd6, 0);
    fetch(6'h04, 6'h00); zero = 1'b0;
    cyc("beq_z0",  11, 0,0,0,0,0, 0,0,1,3'd0,1,0, 4'd6, 0);
    fetch(6'h05, 6'h00); zero = 1'b1;
    cyc("bne_z1",  11, 0,0,0,0,0, 0,0,1,3'd0,1,0, 4'd6, 0);
    fetch(6'h05, 6'h00); zero = 1'b0;
    cyc("bne_z0",  11, 0,0,0,0,0, 0,0,1,3'd0,1,1, 4'd6, 0);

    fetch(6'h08, 6'h00);
    cyc("addi_exi", 9, 0,0,0,0,0, 0,0,1,3'd2,0,0, 4'd2, 0);
    cyc("addi_iwb",10, 0,0,0,0,1, 0,0,0,3'd0,0,0, 4'd2, 0);
    fetch(6'h0F, 6'h00);
    cyc("lui_exi",  9, 0,0,0,0,0, 0,0,1,3'd0,0,0, 4'd2, 0);
    cyc("lui_iwb", 10, 0,0,0,0,1, 0,3,0,3'd0,0,0, 4'd2, 0);
    fetch(6'h0D, 6'h00);
    cyc("ori_exi",  9, 0,0,0,0,0, 0,0,1,3'd5,0,0, 4'd1, 0);
    cyc("ori_iwb", 10, 0,0,0,0,1, 0,0,0,3'd0,0,0, 4'd2, 0);

    fetch(6'h02, 6'h00);
    cyc("j",       12, 0,0,0,0,0, 0,0,0,3'd0,2,1, 4'd2, 0);
    fetch(6'h03, 6'h00);
    cyc("jal",     13, 0,0,0,0,1, 2,2,0,3'd0,2,1, 4'd2, 0);
    fetch(6'h00, 6'h08);
    cyc("jr",      14, 0,0,0,0,0, 0,0,0,3'd0,3,1, 4'd2, 0);

    OPcode = 6'h3F; Fun = 6'h00; MIO_ready = 1'b1;
    cyc("ill_if",   1, 1,0,0,1,0, 0,0,0,3'd1,0,1, 4'd2, 0);
    cyc("ill_id",   2, 0,0,0,0,0, 0,0,0,3'd3,0,0, 4'd2, 1);

    fetch(6'h2B, 6'h00);
    cyc("sw_ma",    3, 0,0,0,0,0, 0,0,1,3'd2,0,0, 4'd2, 0);
    MIO_ready = 1'b0;
    expect_v("sw_mw",  6, 0,1,1,0,0, 0,0,0,3'd0,0,0, 4'd2, 0);
    @(negedge clk); #1;
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_v("rst_async", 0, 0,0,0,0,0, 0,0,0,3'd0,0,0, 4'd0, 0);
    -> mon_ev;
    #1 clk_en = 1'b1;

    step();
    expect_v("rst_held", 0, 0,0,0,0,0, 0,0,0,3'd0,0,0, 4'd0, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    step();
    MIO_ready = 1'b1;
    cyc("re_if",    1, 1,0,0,1,0, 0,0,0,3'd1,0,1, 4'd2, 0);
    expect_v("re_id",  2, 0,0,0,0,0, 0,0,0,3'd3,0,0, 4'd2, 0);
    @(negedge clk); #1;

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Control FSM for the multi-cycle MIPS datapath. It drives the ALU's 4-bit operation select and consumes the ALU's zero flag, acting as the producing end of that interface. It sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction, and stalls on memory handshakes.

Parameters:
MEM_WAIT, 1, 1 = memory states wait for MIO_ready; 0 = MIO_ready is ignored and memory completes in 1 cycle.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
OPcode  in  6  IR[31:26]; valid from ID onward
Fun  in  6  IR[5:0]; valid from ID onward
zero  in  1  ALU zero flag
MIO_ready  in  1  memory access complete
MemRead / MemWrite  out  1  memory strobes
CPU_MIO  out  1  MemRead | MemWrite
IorD  out  1  address select: 0 = PC, 1 = ALUOut
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write
RegDst  out  2  write register: 0 = rt, 1 = rd, 2 = r31
MemtoReg  out  2  write data: 0 = ALUOut, 1 = MDR, 2 = PC, 3 = imm<<16
ALUSrcA  out  2  ALU A: 0 = PC, 1 = rs, 2 = rt
ALUSrcB  out  3  ALU B: 0 = rt, 1 = const 4, 2 = sext imm, 3 = sext imm<<2, 4 = zext shamt, 5 = zext imm
PCSource  out  2  next PC: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs
PCWrite  out  1  PC load, including resolved branch condition
ALU_operation  out  4  0 AND, 1 OR, 2 ADD, 3 SLL, 4 NOR, 5 SRL, 6 SUB, 7 SLT, 8 XOR, 9 SLTU, 10 SRA
illegal  out  1  one-cycle pulse in ID on an unsupported opcode/funct
state_out  out  4  current state, for debug

Behaviour:
- State register: 4-bit encoded. All outputs are combinational from state, OPcode, Fun, zero and MIO_ready.
- Any output not listed for a state is 0, except ALU_operation, which defaults to 2.
- Reset: asynchronous on rst_n low, into IDLE(0). In IDLE every output is 0, including ALU_operation = 0. IDLE always goes to IF on the next edge.
- Reset mid-operation: all strobes drop immediately. No partial write may be issued after rst_n falls.
- IF(1): MemRead = 1, ALUSrcA = 0, ALUSrcB = 1, op ADD, PCSource = 0. When MIO_ready is high: IRWrite = 1, PCWrite = 1, next ID. Otherwise hold IF with IRWrite and PCWrite both 0.
- ID(2): ALUSrcA = 0, ALUSrcB = 3, op ADD (branch target into ALUOut). Dispatch by opcode:
  - lw/sw → MA
  - R-type jr (funct 0x08) → JR
  - other R-type → EXR
  - addi/slti/andi/ori/xori/lui → EXI
  - beq/bne → BR
  - j → J
  - jal → JAL
  - anything else → illegal = 1, next IF, no writes.
- MA(3): ALUSrcA = 1, ALUSrcB = 2, op ADD. lw → MR, sw → MW.
- MR(4): MemRead = 1, IorD = 1. Wait for MIO_ready → LWB.
- LWB(5): RegWrite = 1, RegDst = 0, MemtoReg = 1 → IF.
- MW(6): MemWrite = 1, IorD = 1. Wait for MIO_ready → IF.
- EXR(7): ALUSrcA = 1, ALUSrcB = 0, op from funct: 20→2, 22→6, 24→0, 25→1, 26→8, 27→4, 2A→7, 2B→9. Next RWB.
  - Shifts use ALUSrcA = 2, ALUSrcB = 4 with funct 00→3, 02→5, 03→10.
- RWB(8): RegWrite = 1, RegDst = 1, MemtoReg = 0. ALU_operation holds the EXR value → IF.
- EXI(9): ALUSrcA = 1. Next IWB.
  - addi/slti: ALUSrcB = 2, op 2 or 7.
  - andi/ori/xori: ALUSrcB = 5, op 0/1/8.
- IWB(10): RegWrite = 1, RegDst = 0. MemtoReg = 3 for lui, 0 otherwise → IF.
- BR(11): ALUSrcA = 1, ALUSrcB = 0, op SUB, PCSource = 1. PCWrite = (beq & zero) | (bne & ~zero) → IF.
- J(12): PCSource = 2, PCWrite = 1 → IF.
- JAL(13): J outputs plus RegWrite = 1, RegDst = 2, MemtoReg = 2 (PC already holds PC+4) → IF.
- JR(14): PCSource = 3, PCWrite = 1 → IF.
- State 15 is unreachable and recovers to IF.
- Latency in cycles: R/I-type 4, lw 5, sw 4, branch/jump 3, each plus memory stall cycles.

Decomposition:
- Shared package holds the opcode and funct constants, the ALU_operation encodings (also used by the ALU), the state encodings, and the mux-select encodings.
- One sub-module, alu_op_decode: combinational mapping of funct/opcode to the 4-bit op.

Test Plan:
- rst_n = 0 → all outputs 0, state_out = 0; release → state_out 1 on the next edge, MemRead = 1, ALU_operation = 2.
- add (OP 00, Fun 20), MIO_ready = 1 → states 1,2,7,8,1; EXR op = 2; RWB RegWrite = 1, RegDst = 1.
- sll (Fun 00) → EXR ALUSrcA = 2, ALUSrcB = 4, op = 3; sltu (Fun 2B) → op = 9.
- lw (OP 23) with MIO_ready low for 2 cycles in MR → MR held 3 cycles with MemRead = 1, IorD = 1; then LWB with MemtoReg = 1.
- beq with zero = 1 → PCWrite = 1, PCSource = 1; bne with zero = 1 → PCWrite = 0; both op = 6.
- OP 3F → illegal pulses for 1 cycle in ID, next IF, no writes. rst_n falls during MW → MemWrite goes to 0 with no clock edge required.
